// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the main-memory arbiter.
//   - state_t     : arbiter states
//   - BLOCK_WORDS : words per cache block, WOFF_W word-offset width
//   - REQ_*       : request slot indices, lower index wins arbitration
//   - pick_req    : fixed-priority choice of the next state from IDLE
package mem_ctrl_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int WOFF_W      = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_FILL  = 2'd1,
    D_WRITE = 2'd2,
    I_FILL  = 2'd3
  } state_t;

  // A store miss must be allocated before its write goes out, so the
  // D-cache miss outranks the write-through store.
  localparam int REQ_D_MISS  = 0;
  localparam int REQ_D_WRITE = 1;
  localparam int REQ_I_MISS  = 2;
  localparam int NUM_REQ     = 3;

  function automatic state_t pick_req(input logic [NUM_REQ-1:0] req);
    state_t s;
    s = IDLE;
    if (req[REQ_D_MISS])       s = D_FILL;
    else if (req[REQ_D_WRITE]) s = D_WRITE;
    else if (req[REQ_I_MISS])  s = I_FILL;
    return s;
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_seq.sv
// fill_seq: issue/receive counter pair for one block fill.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   run_i          : a fill is in progress
//   data_valid_i   : memory read data returning this cycle
//   issue_o        : issue a read this cycle, word index iss_idx_o
//   rcv_we_o       : accept returning word, index rcv_idx_o
//   last_o         : the accepted word is the last of the block
module fill_seq #(
  parameter  int WORDS = 8,
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             data_valid_i,
  output logic             issue_o,
  output logic [OFF_W-1:0] iss_idx_o,
  output logic [OFF_W-1:0] rcv_idx_o,
  output logic             rcv_we_o,
  output logic             last_o
);

  // One extra bit on the issue counter marks "all words issued".
  logic [OFF_W:0]   iss_q, iss_d;
  logic [OFF_W-1:0] rcv_q, rcv_d;

  always_comb begin
    issue_o   = run_i & (iss_q < (OFF_W+1)'(WORDS));
    // Only accept data for words already issued; stray valids are dropped.
    rcv_we_o  = run_i & data_valid_i & ({1'b0, rcv_q} < iss_q);
    last_o    = rcv_we_o & (rcv_q == OFF_W'(WORDS-1));
    iss_idx_o = iss_q[OFF_W-1:0];
    rcv_idx_o = rcv_q;
    iss_d     = iss_q;
    rcv_d     = rcv_q;
    if (last_o) begin
      iss_d = '0;
      rcv_d = '0;
    end else begin
      if (issue_o)  iss_d = iss_q + 1'b1;
      if (rcv_we_o) rcv_d = rcv_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_q <= '0;
      rcv_q <= '0;
    end else begin
      iss_q <= iss_d;
      rcv_q <= rcv_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the shared main memory between I-cache fills,
// D-cache fills and D-cache write-through stores.
//   requests : i_miss_i/_addr, d_miss_i/_addr, d_write_req_i/_addr/_data
//   memory   : mem_enable_o, mem_wr_o, mem_addr_o, mem_wdata_o,
//              mem_data_valid_i, mem_rdata_i
//   caches   : fill_data_o, fill_word_o, i/d_fill_we_o, i/d_fill_done_o,
//              d_write_ack_o
//   pipeline : stall_if_o, stall_mem_o
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = mem_ctrl_pkg::BLOCK_WORDS
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           i_miss_i,
  input  logic [ADDR_W-1:0]              i_miss_addr_i,
  input  logic                           d_miss_i,
  input  logic [ADDR_W-1:0]              d_miss_addr_i,
  input  logic                           d_write_req_i,
  input  logic [ADDR_W-1:0]              d_write_addr_i,
  input  logic [DATA_W-1:0]              d_write_data_i,
  output logic                           mem_enable_o,
  output logic                           mem_wr_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic [DATA_W-1:0]              mem_wdata_o,
  input  logic                           mem_data_valid_i,
  input  logic [DATA_W-1:0]              mem_rdata_i,
  output logic [DATA_W-1:0]              fill_data_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_o,
  output logic                           i_fill_we_o,
  output logic                           d_fill_we_o,
  output logic                           i_fill_done_o,
  output logic                           d_fill_done_o,
  output logic                           d_write_ack_o,
  output logic                           stall_if_o,
  output logic                           stall_mem_o
);
  import mem_ctrl_pkg::*;

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  // Block address excludes the word offset and the byte-in-word bit.
  localparam int BLK_W = ADDR_W - OFF_W - 1;

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [NUM_REQ-1:0] req;
  logic               run, issue, rcv_we, last;
  logic [OFF_W-1:0]   iss_idx, rcv_idx;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr_i[OFF_W:0], d_miss_addr_i[OFF_W:0]};

  assign run = (state_q == D_FILL) || (state_q == I_FILL);

  fill_seq #(.WORDS(BLOCK_WORDS)) u_seq (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .run_i        (run),
    .data_valid_i (mem_data_valid_i),
    .issue_o      (issue),
    .iss_idx_o    (iss_idx),
    .rcv_idx_o    (rcv_idx),
    .rcv_we_o     (rcv_we),
    .last_o       (last)
  );

  always_comb begin
    req              = '0;
    req[REQ_D_MISS]  = d_miss_i;
    req[REQ_D_WRITE] = d_write_req_i;
    req[REQ_I_MISS]  = i_miss_i;
  end

  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    mem_enable_o  = 1'b0;
    mem_wr_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    fill_data_o   = '0;
    fill_word_o   = '0;
    i_fill_we_o   = 1'b0;
    d_fill_we_o   = 1'b0;
    i_fill_done_o = 1'b0;
    d_fill_done_o = 1'b0;
    d_write_ack_o = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = pick_req(req);
        if (state_d == D_FILL) blk_d = d_miss_addr_i[ADDR_W-1:OFF_W+1];
        if (state_d == I_FILL) blk_d = i_miss_addr_i[ADDR_W-1:OFF_W+1];
      end
      D_FILL, I_FILL: begin
        mem_enable_o = issue;
        if (issue) mem_addr_o = {blk_q, iss_idx, 1'b0};
        if (rcv_we) begin
          fill_data_o = mem_rdata_i;
          fill_word_o = rcv_idx;
        end
        // Completion follows the returned data only; the request line may
        // already have dropped (flushed miss) and the block is still written.
        if (state_q == D_FILL) begin
          d_fill_we_o   = rcv_we;
          d_fill_done_o = last;
        end else begin
          i_fill_we_o   = rcv_we;
          i_fill_done_o = last;
        end
        if (last) state_d = IDLE;
      end
      D_WRITE: begin
        mem_enable_o  = 1'b1;
        mem_wr_o      = 1'b1;
        mem_addr_o    = d_write_addr_i;
        mem_wdata_o   = d_write_data_i;
        d_write_ack_o = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end

  assign stall_if_o  = i_miss_i & ~i_fill_done_o;
  assign stall_mem_o = (d_miss_i & ~d_fill_done_o) | (d_write_req_i & ~d_write_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: pipelined memory model with fixed
// latency, table-driven fills/writes, directed corner sequences and a
// randomized phase checked against request-level rules.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr;
  logic [15:0] i_addr, d_addr, w_addr, w_data;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_write_ack;
  logic        stall_if, stall_mem;
  logic        mv, inj;
  int          checks = 0, failures = 0;
  int          cyc = 0, lat = 4;

  assign mem_data_valid = mv | inj;

  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .i_miss_i(i_miss), .i_miss_addr_i(i_addr),
    .d_miss_i(d_miss), .d_miss_addr_i(d_addr),
    .d_write_req_i(d_wr), .d_write_addr_i(w_addr), .d_write_data_i(w_data),
    .mem_enable_o(mem_enable), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_data_valid_i(mem_data_valid),
    .mem_rdata_i(mem_rdata), .fill_data_o(fill_data), .fill_word_o(fill_word),
    .i_fill_we_o(i_fill_we), .d_fill_we_o(d_fill_we),
    .i_fill_done_o(i_fill_done), .d_fill_done_o(d_fill_done),
    .d_write_ack_o(d_write_ack), .stall_if_o(stall_if), .stall_mem_o(stall_mem)
  );

  initial forever #5 clk = ~clk;

  // ---------------- memory model ----------------
  typedef struct { int due; logic [15:0] d; } rd_t;
  rd_t         rq[$];
  logic [15:0] wmem [int];

  function automatic logic [15:0] mem_rd(input logic [14:0] widx);
    if (wmem.exists(int'(widx))) return wmem[int'(widx)];
    return 16'(widx * 37) ^ 16'hC3A5;
  endfunction

  // Cycle k runs from posedge k to posedge k+1. A read issued in cycle k
  // returns in cycle k+lat.
  initial begin
    mv = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        mv = 1'b1; mem_rdata = rq[0].d; void'(rq.pop_front());
      end else begin
        mv = 1'b0; mem_rdata = '0;
      end
      @(negedge clk);
      if (rst) rq.delete();
      else if (mem_enable) begin
        if (mem_wr) wmem[int'(mem_addr[15:1])] = mem_wdata;
        else rq.push_back('{cyc + lat, mem_rd(mem_addr[15:1])});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {mem_enable, mem_wr, i_fill_we, d_fill_we, i_fill_done,
                      d_fill_done, d_write_ack, stall_if, stall_mem}, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_wdata"}, mem_wdata, 0);
    chk({nm, "_fill"}, {fill_data, fill_word}, 0);
  endtask

  task automatic drive_edge();
    @(posedge clk); #2;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          lat;
    logic [15:0] exp_a0;   // first issued address (write: store address)
    logic [15:0] exp_a7;   // last issued fill address
    int          exp_done; // done / ack cycle relative to request cycle 0
  } vec_t;

  task automatic run_i_fill(input vec_t v, input int drop_at, input string nm);
    int c0, k, nwe, niss, first_we, done_k;
    bit done;
    lat = v.lat;
    drive_edge();
    i_miss = 1'b1; i_addr = v.addr; c0 = cyc;
    nwe = 0; niss = 0; first_we = -1; done_k = -1; done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      k = cyc - c0;
      if (mem_enable) begin
        niss++;
        chk({nm, "_rd"}, mem_wr, 0);
        chk({nm, "_iss_window"}, (k >= 1 && k <= 8), 1);
        if (k == 1) chk({nm, "_addr_w0"}, mem_addr, v.exp_a0);
        if (k == 8) chk({nm, "_addr_w7"}, mem_addr, v.exp_a7);
      end
      if (i_fill_we) begin
        if (first_we < 0) first_we = k;
        chk({nm, "_word"}, fill_word, nwe[2:0]);
        chk({nm, "_data"}, fill_data, mem_rd({v.exp_a0[15:4], nwe[2:0]}));
        nwe++;
      end
      chk({nm, "_no_dwe"}, d_fill_we, 0);
      if (i_fill_done) begin
        done = 1; done_k = k;
        chk({nm, "_stall_if_done"}, stall_if, 0);
      end else if (drop_at < 0 || k < drop_at) chk({nm, "_stall_if"}, stall_if, 1);
      drive_edge();
      if (done || (cyc - c0) == drop_at) i_miss = 1'b0;
    end
    i_miss = 1'b0;
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_issues"}, niss, 8);
    chk({nm, "_we_count"}, nwe, 8);
    chk({nm, "_first_we"}, first_we, 1 + v.lat);
    chk({nm, "_done_cyc"}, done_k, v.exp_done);
  endtask

  task automatic run_write(input vec_t v, input string nm);
    int c0, k, ack_k;
    ack_k = -1;
    drive_edge();
    d_wr = 1'b1; w_addr = v.addr; w_data = v.data; c0 = cyc;
    for (int n = 0; n < 10 && ack_k < 0; n++) begin
      @(negedge clk);
      k = cyc - c0;
      if (d_write_ack) begin
        ack_k = k;
        chk({nm, "_en_wr"}, {mem_enable, mem_wr}, 2'b11);
        chk({nm, "_addr"}, mem_addr, v.exp_a0);
        chk({nm, "_wdata"}, mem_wdata, v.data);
        chk({nm, "_stall_ack"}, stall_mem, 0);
      end else begin
        chk({nm, "_idle_en"}, mem_enable, 0);
        chk({nm, "_stall"}, stall_mem, 1);
      end
      drive_edge();
      if (ack_k >= 0) d_wr = 1'b0;
    end
    d_wr = 1'b0;
    chk({nm, "_ack_cyc"}, ack_k, v.exp_done);
    @(negedge clk);
    chk({nm, "_back_idle"}, {mem_enable, d_write_ack}, 0);
  endtask

  // ---------------- randomized phase ----------------
  task automatic run_random(input int ncyc, input int l);
    int  n, icnt, dcnt, age_i, age_d, age_w;
    bit  ip, dp, wp, ic, dc, wc, pd_prev;
    lat = l;
    n = 0; icnt = 0; dcnt = 0; age_i = 0; age_d = 0; age_w = 0;
    ip = 0; dp = 0; wp = 0; ic = 0; dc = 0; wc = 0; pd_prev = 0;
    while ((n < ncyc || ip || dp || wp) && n < ncyc + 2000) begin
      @(negedge clk);
      chk("r_stall_if", stall_if, i_miss & ~i_fill_done);
      chk("r_stall_mem", stall_mem, (d_miss & ~d_fill_done) | (d_wr & ~d_write_ack));
      // First word of a new fill: the block chosen at acceptance.
      if (mem_enable && !mem_wr && mem_addr[3:1] == 3'd0) begin
        if (pd_prev) chk("r_prio_dblk", mem_addr[15:4], d_addr[15:4]);
        else         chk("r_iblk", mem_addr[15:4], i_addr[15:4]);
      end
      if (mem_enable && mem_wr) begin
        chk("r_wr_pending", wp, 1);
        chk("r_wr_addr", mem_addr, w_addr);
        chk("r_wr_data", mem_wdata, w_data);
        chk("r_wr_ack", d_write_ack, 1);
        chk("r_wr_after_dmiss", pd_prev, 0);
      end
      if (d_write_ack) wc = 1;
      if (i_fill_we) begin
        chk("r_i_word", fill_word, icnt[2:0]);
        chk("r_i_data", fill_data, mem_rd({i_addr[15:4], icnt[2:0]}));
        icnt++;
      end
      if (i_fill_done) begin chk("r_i_done_cnt", icnt, 8); icnt = 0; ic = 1; end
      if (d_fill_we) begin
        chk("r_d_word", fill_word, dcnt[2:0]);
        chk("r_d_data", fill_data, mem_rd({d_addr[15:4], dcnt[2:0]}));
        dcnt++;
      end
      if (d_fill_done) begin chk("r_d_done_cnt", dcnt, 8); dcnt = 0; dc = 1; end
      if (ip && ++age_i > 300) begin chk("r_i_timeout", 0, 1); ic = 1; end
      if (dp && ++age_d > 300) begin chk("r_d_timeout", 0, 1); dc = 1; end
      if (wp && ++age_w > 300) begin chk("r_w_timeout", 0, 1); wc = 1; end
      pd_prev = d_miss;
      drive_edge();
      n++;
      if (ic) begin i_miss = 0; ip = 0; ic = 0; age_i = 0; end
      else if (!ip && n < ncyc && $urandom_range(0, 11) == 0) begin
        i_addr = 16'($urandom); i_miss = 1; ip = 1;
      end
      if (dc) begin d_miss = 0; dp = 0; dc = 0; age_d = 0; end
      else if (!dp && n < ncyc && $urandom_range(0, 15) == 0) begin
        d_addr = 16'($urandom); d_miss = 1; dp = 1;
      end
      if (wc) begin d_wr = 0; wp = 0; wc = 0; age_w = 0; end
      else if (!wp && n < ncyc && $urandom_range(0, 15) == 0) begin
        w_addr = 16'($urandom); w_data = 16'($urandom); d_wr = 1; wp = 1;
      end
    end
    chk("r_drained", {ip, dp, wp}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[5];
    int   c0, k, ddone, iiss, idone, dn, inn, ack_k;

    vecs[0] = '{0, 16'h1234, 16'h0000, 4, 16'h1230, 16'h123E, 12};
    vecs[1] = '{0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h000E, 9};
    vecs[2] = '{0, 16'hFFFF, 16'h0000, 3, 16'hFFF0, 16'hFFFE, 11};
    vecs[3] = '{0, 16'h00A7, 16'h0000, 6, 16'h00A0, 16'h00AE, 14};
    vecs[4] = '{1, 16'h0040, 16'hBEEF, 2, 16'h0040, 16'h0000, 1};

    rst = 1; i_miss = 0; d_miss = 0; d_wr = 0; inj = 0;
    i_addr = 0; d_addr = 0; w_addr = 0; w_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    drive_edge();
    rst = 0;
    @(negedge clk);
    chk_all_zero("idle");

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].is_wr) run_write(vecs[i], $sformatf("vec%0d", i));
      else run_i_fill(vecs[i], -1, $sformatf("vec%0d", i));
    end

    // D and I misses together: D block first, I accepted the cycle after
    // d_fill_done and issuing its first word one cycle later.
    lat = 2;
    drive_edge();
    d_miss = 1; d_addr = 16'h2000; i_miss = 1; i_addr = 16'h1234; c0 = cyc;
    ddone = -1; iiss = -1; idone = -1; dn = 0; inn = 0;
    for (int n = 0; n < 80 && idone < 0; n++) begin
      @(negedge clk);
      k = cyc - c0;
      if (k == 1) chk("di_first_addr", mem_addr, 16'h2000);
      if (mem_enable && mem_addr == 16'h1230 && iiss < 0) iiss = k;
      if (d_fill_we) begin
        chk("di_d_data", fill_data, mem_rd({12'h200, dn[2:0]}));
        dn++;
      end
      if (i_fill_we) begin
        chk("di_i_after_d", (ddone >= 0), 1);
        chk("di_i_data", fill_data, mem_rd({12'h123, inn[2:0]}));
        inn++;
      end
      if (d_fill_done) ddone = k;
      if (i_fill_done) idone = k;
      else chk("di_stall_if", stall_if, 1);
      drive_edge();
      if (ddone >= 0) d_miss = 0;
    end
    i_miss = 0;
    chk("di_d_done", ddone, 10);
    chk("di_d_words", dn, 8);
    chk("di_i_word0", iiss, 12);
    chk("di_i_done", idone, 21);
    chk("di_i_words", inn, 8);

    // D miss together with a store: fill, then write; stall_mem held to ack.
    lat = 3;
    drive_edge();
    d_miss = 1; d_addr = 16'h0040; d_wr = 1; w_addr = 16'h0044; w_data = 16'h1111;
    c0 = cyc; ddone = -1; ack_k = -1;
    for (int n = 0; n < 60 && ack_k < 0; n++) begin
      @(negedge clk);
      k = cyc - c0;
      if (d_fill_done) ddone = k;
      if (d_write_ack) begin
        ack_k = k;
        chk("dw_wr", {mem_enable, mem_wr}, 2'b11);
        chk("dw_addr", mem_addr, 16'h0044);
        chk("dw_wdata", mem_wdata, 16'h1111);
        chk("dw_stall_ack", stall_mem, 0);
      end else begin
        chk("dw_stall_mem", stall_mem, 1);
        if (mem_enable) chk("dw_no_early_wr", mem_wr, 0);
      end
      drive_edge();
      if (ddone >= 0) d_miss = 0;
      if (ack_k >= 0) d_wr = 0;
    end
    d_miss = 0; d_wr = 0;
    chk("dw_fill_done", ddone, 11);
    chk("dw_ack_cyc", ack_k, 13);

    // Reset in cycle 5 of an I fill, then a clean restart.
    lat = 4;
    drive_edge();
    i_miss = 1; i_addr = 16'h1234; c0 = cyc;
    while (cyc - c0 < 5) drive_edge();
    rst = 1; i_miss = 0;
    drive_edge();
    rst = 0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_stale", {i_fill_we, i_fill_done, mem_enable}, 0);
    end
    run_i_fill(vecs[0], -1, "rst_restart");

    // Miss squashed in cycle 3: fill still completes.
    run_i_fill(vecs[0], 3, "drop");

    // Stray valids while idle must not write either cache.
    for (int n = 0; n < 4; n++) begin
      drive_edge();
      inj = 1;
      @(negedge clk);
      chk("idle_valid", {i_fill_we, d_fill_we, i_fill_done, d_fill_done}, 0);
    end
    drive_edge();
    inj = 0;

    run_random(800, 1);
    run_random(800, int'($urandom_range(2, 6)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
